// File: rtl/lpll_clkgen_div.sv
// Programmable multi-channel clock divider with per-channel phase, clock enables and lock flag.
// Optional CLKGEN_DUTY_EN: programmable high time per channel (default: high = div>>1).
module lpll_clkgen_div #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DEF_DIV = 2,
   localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] wr_phase,
   input  logic [DIV_W-1:0] wr_high,
   input  logic             apply,
   output logic [NCH-1:0]   ce,
   output logic [NCH-1:0]   outclk,
   output logic             locked
);

   typedef logic [DIV_W-1:0] word_t;

   localparam word_t DefDiv  = DIV_W'(DEF_DIV);
   localparam word_t DefHigh = DIV_W'(DEF_DIV >> 1);
   localparam word_t One     = DIV_W'(1);
   localparam word_t Two     = DIV_W'(2);

   word_t sh_div_q   [NCH];
   word_t sh_div_d   [NCH];
   word_t sh_phase_q [NCH];
   word_t sh_phase_d [NCH];
   word_t div_q      [NCH];
   word_t div_d      [NCH];
   word_t high_q     [NCH];
   word_t high_d     [NCH];
   word_t cnt_q      [NCH];
   word_t cnt_d      [NCH];
   word_t cl_div     [NCH];
   word_t cl_phase   [NCH];
   word_t cl_high    [NCH];

`ifdef CLKGEN_DUTY_EN
   word_t sh_high_q  [NCH];
   word_t sh_high_d  [NCH];
`else
   logic  unused_wr_high;
   assign unused_wr_high = ^wr_high;
`endif

   logic [NCH-1:0] ce_q, ce_d;
   logic [NCH-1:0] outclk_q, outclk_d;
   logic [NCH-1:0] seen_q, seen_d;
   logic [NCH-1:0] idle;
   logic           locked_q, locked_d;

   // Values the active registers take on apply, after clamping the shadows.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         cl_div[i]   = (sh_div_q[i] == One) ? Two : sh_div_q[i];
         cl_phase[i] = sh_phase_q[i];
`ifdef CLKGEN_DUTY_EN
         cl_high[i]  = sh_high_q[i];
`else
         cl_high[i]  = cl_div[i] >> 1;
`endif
         if (cl_div[i] == '0) begin
            cl_phase[i] = '0;
            cl_high[i]  = '0;
         end else begin
            if (cl_phase[i] >= cl_div[i]) cl_phase[i] = cl_div[i] - One;
            if (cl_high[i] >= cl_div[i])  cl_high[i]  = cl_div[i] - One;
            if (cl_high[i] == '0)         cl_high[i]  = One;
         end
      end
   end

   always_comb begin
      sh_div_d   = sh_div_q;
      sh_phase_d = sh_phase_q;
`ifdef CLKGEN_DUTY_EN
      sh_high_d  = sh_high_q;
`endif
      div_d      = div_q;
      high_d     = high_q;
      cnt_d      = cnt_q;
      ce_d       = '0;
      outclk_d   = '0;
      idle       = '0;

      for (int i = 0; i < NCH; i++) begin
         // Out-of-range channel indices never match and are dropped.
         if (wr_en && (wr_ch == CH_W'(i))) begin
            sh_div_d[i]   = wr_div;
            sh_phase_d[i] = wr_phase;
`ifdef CLKGEN_DUTY_EN
            sh_high_d[i]  = wr_high;
`endif
         end

         idle[i] = (div_q[i] == '0);

         if (apply) begin
            div_d[i]  = cl_div[i];
            high_d[i] = cl_high[i];
            cnt_d[i]  = cl_phase[i];
         end else if (idle[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= div_q[i] - One) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + One;
         end

         // Decode from next-state so the registered outputs line up with the counter.
         outclk_d[i] = (div_d[i] != '0) && (cnt_d[i] < high_d[i]);
         ce_d[i]     = (div_d[i] != '0) && (cnt_d[i] == div_d[i] - One);
      end

      if (apply) begin
         seen_d   = '0;
         locked_d = 1'b0;
      end else begin
         seen_d   = seen_q | ce_q;
         locked_d = locked_q | (&(seen_q | ce_q | idle));
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            sh_div_q[i]   <= DefDiv;
            sh_phase_q[i] <= '0;
`ifdef CLKGEN_DUTY_EN
            sh_high_q[i]  <= DefHigh;
`endif
            div_q[i]      <= DefDiv;
            high_q[i]     <= DefHigh;
            cnt_q[i]      <= '0;
         end
         ce_q     <= '0;
         outclk_q <= '0;
         seen_q   <= '0;
         locked_q <= 1'b0;
      end else begin
         sh_div_q   <= sh_div_d;
         sh_phase_q <= sh_phase_d;
`ifdef CLKGEN_DUTY_EN
         sh_high_q  <= sh_high_d;
`endif
         div_q      <= div_d;
         high_q     <= high_d;
         cnt_q      <= cnt_d;
         ce_q       <= ce_d;
         outclk_q   <= outclk_d;
         seen_q     <= seen_d;
         locked_q   <= locked_d;
      end
   end

   assign ce     = ce_q;
   assign outclk = outclk_q;
   assign locked = locked_q;

endmodule
